// File: rtl/index_cursor_ctrl.sv
// index_cursor_ctrl
// Drives the hand-selection highlight: walks a cursor over the cards in the
// player's hand, offers the chosen card to game logic over valid/ready, and
// produces a tear-free highlight rectangle that only moves at frame starts
// and blinks while a selection is waiting to be accepted.

module index_cursor_ctrl #(
    parameter int MAX_CARDS    = 16,
    parameter int X_ORIGIN     = 40,
    parameter int Y_ORIGIN     = 400,
    parameter int CARD_PITCH   = 36,
    parameter int CARD_W       = 32,
    parameter int CARD_H       = 48,
    parameter int BLINK_FRAMES = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           turn_en,
    input  logic [$clog2(MAX_CARDS+1)-1:0] hand_count,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           btn_select,
    input  logic                           frame_start,
    input  logic                           sel_ready,
    output logic                           sel_valid,
    output logic [$clog2(MAX_CARDS)-1:0]   sel_index,
    output logic [$clog2(MAX_CARDS)-1:0]   cursor_idx,
    output logic                           hl_visible,
    output logic [9:0]                     x_pin,
    output logic [9:0]                     y_pin,
    output logic [9:0]                     x_width,
    output logic [9:0]                     y_width
);

    // Index width for the cursor, hand-count width (must hold MAX_CARDS itself)
    localparam int IW = $clog2(MAX_CARDS);
    localparam int HW = $clog2(MAX_CARDS + 1);
    // Blink counter only needs to reach BLINK_FRAMES-1
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int LUT_DEPTH = 2 ** IW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BROWSE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   cursor_reg;
    logic [IW-1:0]   sel_index_reg;
    logic            sel_valid_reg;
    logic            hl_visible_reg;
    logic [9:0]      x_pin_reg;
    logic [BW-1:0]   blink_cnt_reg;
    logic            blink_on_reg;

    // Combinational helpers
    logic [HW-1:0]   cursor_ext;
    logic [HW-1:0]   hand_last;
    logic            hand_active;
    logic            cursor_oob;
    logic            handshake;
    logic            move_left;
    logic            move_right;
    logic [IW-1:0]   cursor_right_next;
    logic [IW-1:0]   cursor_left_next;
    logic [BW-1:0]   blink_cnt_next;
    logic            blink_on_next;
    logic            hl_visible_next;

    // Highlight left edge for every cursor position, precomputed as constants
    // so the frame latch is a plain table lookup instead of a multiplier.
    logic [9:0]      x_lut [LUT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_x_lut
            assign x_lut[gi] = 10'(X_ORIGIN + gi * CARD_PITCH);
        end
    endgenerate

    // Cursor arithmetic: wrap is done explicitly against the live hand size
    always_comb begin
        cursor_ext  = {{(HW-IW){1'b0}}, cursor_reg};
        hand_last   = hand_count - 1'b1;
        hand_active = turn_en && (hand_count != '0);
        cursor_oob  = (cursor_ext >= hand_count);
        handshake   = sel_valid_reg && sel_ready;
        move_left   = btn_left && !btn_right;
        move_right  = btn_right && !btn_left;

        if (cursor_ext == hand_last) begin
            cursor_right_next = '0;
        end else begin
            cursor_right_next = cursor_reg + 1'b1;
        end

        if (cursor_reg == '0) begin
            cursor_left_next = hand_last[IW-1:0];
        end else begin
            cursor_left_next = cursor_reg - 1'b1;
        end
    end

    // Blink phase as it would stand after this cycle's frame_start, used both
    // to advance the counter and to decide what the renderer latches now.
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        blink_on_next  = blink_on_reg;
        if (frame_start) begin
            if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_next = '0;
                blink_on_next  = !blink_on_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
            end
        end

        hl_visible_next = (state_reg == ST_BROWSE) ||
                          ((state_reg == ST_COMMIT) && blink_on_next);
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cursor_reg     <= '0;
            sel_valid_reg  <= 1'b0;
            sel_index_reg  <= '0;
            hl_visible_reg <= 1'b0;
            x_pin_reg      <= 10'(X_ORIGIN);
            blink_cnt_reg  <= '0;
            blink_on_reg   <= 1'b1;
        end else begin
            // Display latch: only moves at frame boundaries, using the
            // cursor as it stood before any same-cycle button move.
            if (frame_start) begin
                x_pin_reg      <= x_lut[cursor_reg];
                hl_visible_reg <= hl_visible_next;
            end

            // Blink runs only while a selection stays pending; anything else
            // (including the accepting cycle) re-arms it to on/zero.
            if ((state_reg == ST_COMMIT) && !handshake) begin
                blink_cnt_reg <= blink_cnt_next;
                blink_on_reg  <= blink_on_next;
            end else begin
                blink_cnt_reg <= '0;
                blink_on_reg  <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (hand_active) begin
                        state_reg  <= ST_BROWSE;
                        cursor_reg <= '0;
                    end
                end

                ST_BROWSE: begin
                    if (!hand_active) begin
                        state_reg <= ST_IDLE;
                    end else if (cursor_oob) begin
                        // Hand shrank under the cursor: snap to the last card
                        cursor_reg <= hand_last[IW-1:0];
                    end else if (btn_select) begin
                        state_reg     <= ST_COMMIT;
                        sel_valid_reg <= 1'b1;
                        sel_index_reg <= cursor_reg;
                    end else if (move_left) begin
                        cursor_reg <= cursor_left_next;
                    end else if (move_right) begin
                        cursor_reg <= cursor_right_next;
                    end
                end

                ST_COMMIT: begin
                    // Offer is never withdrawn; only the handshake leaves
                    if (handshake) begin
                        sel_valid_reg <= 1'b0;
                        state_reg     <= hand_active ? ST_BROWSE : ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel_valid  = sel_valid_reg;
    assign sel_index  = sel_index_reg;
    assign cursor_idx = cursor_reg;
    assign hl_visible = hl_visible_reg;
    assign x_pin      = x_pin_reg;
    assign y_pin      = 10'(Y_ORIGIN);
    assign x_width    = 10'(CARD_W);
    assign y_width    = 10'(CARD_H);

endmodule

// File: tb/tb_index_cursor_ctrl.sv
// tb_index_cursor_ctrl
// Directed scenarios followed by random stimulus. A behavioural model predicts
// the outputs after every clock edge; a monitor process pops the predictions
// and compares, and separately checks each accepted selection index.

module tb_index_cursor_ctrl;

    localparam int MAX_CARDS    = 16;
    localparam int X_ORIGIN     = 40;
    localparam int Y_ORIGIN     = 400;
    localparam int CARD_PITCH   = 36;
    localparam int CARD_W       = 32;
    localparam int CARD_H       = 48;
    localparam int BLINK_FRAMES = 15;

    logic       clk;
    logic       rst_n;
    logic       turn_en;
    logic [4:0] hand_count;
    logic       btn_left;
    logic       btn_right;
    logic       btn_select;
    logic       frame_start;
    logic       sel_ready;
    logic       sel_valid;
    logic [3:0] sel_index;
    logic [3:0] cursor_idx;
    logic       hl_visible;
    logic [9:0] x_pin;
    logic [9:0] y_pin;
    logic [9:0] x_width;
    logic [9:0] y_width;

    index_cursor_ctrl #(
        .MAX_CARDS   (MAX_CARDS),
        .X_ORIGIN    (X_ORIGIN),
        .Y_ORIGIN    (Y_ORIGIN),
        .CARD_PITCH  (CARD_PITCH),
        .CARD_W      (CARD_W),
        .CARD_H      (CARD_H),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .turn_en    (turn_en),
        .hand_count (hand_count),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_select (btn_select),
        .frame_start(frame_start),
        .sel_ready  (sel_ready),
        .sel_valid  (sel_valid),
        .sel_index  (sel_index),
        .cursor_idx (cursor_idx),
        .hl_visible (hl_visible),
        .x_pin      (x_pin),
        .y_pin      (y_pin),
        .x_width    (x_width),
        .y_width    (y_width)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int cursor;
        int valid;
        int idx;
        int x;
        int vis;
    } snap_t;

    snap_t exp_q[$];
    int    sel_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Model of the player-visible behaviour
    localparam int M_OFF      = 0;  // not the player's turn
    localparam int M_CHOOSING = 1;  // moving the cursor
    localparam int M_OFFERED  = 2;  // waiting for game logic to take the card
    int m_mode, m_cursor, m_valid, m_idx, m_x, m_vis, m_frames;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Advance the model across one clock edge with the inputs now applied
    function automatic void model_step();
        int  hc;
        int  frames_after;
        bit  live;
        if (!rst_n) begin
            m_mode = M_OFF; m_cursor = 0; m_valid = 0; m_idx = 0;
            m_x = X_ORIGIN; m_vis = 0; m_frames = 0;
            sel_q.delete();
            return;
        end
        hc   = int'(hand_count);
        live = turn_en && (hc != 0);
        frames_after = m_frames + ((m_mode == M_OFFERED && frame_start) ? 1 : 0);
        if (frame_start) begin
            m_x   = (X_ORIGIN + m_cursor * CARD_PITCH) % 1024;
            m_vis = (m_mode == M_CHOOSING) ||
                    (m_mode == M_OFFERED && ((frames_after / BLINK_FRAMES) % 2 == 0));
        end
        m_frames = frames_after;
        case (m_mode)
            M_OFF: if (live) begin m_mode = M_CHOOSING; m_cursor = 0; end
            M_CHOOSING: begin
                if (!live) m_mode = M_OFF;
                else if (m_cursor >= hc) m_cursor = hc - 1;
                else if (btn_select) begin
                    m_mode = M_OFFERED; m_valid = 1; m_idx = m_cursor; m_frames = 0;
                    sel_q.push_back(m_cursor);
                end else if (btn_left && !btn_right) m_cursor = (m_cursor + hc - 1) % hc;
                else if (btn_right && !btn_left) m_cursor = (m_cursor + 1) % hc;
            end
            default: if (sel_ready) begin
                m_valid = 0;
                m_mode  = live ? M_CHOOSING : M_OFF;
            end
        endcase
    endfunction

    // One clock: predict, queue the prediction, wait for the opposite edge
    task automatic tick();
        snap_t s;
        model_step();
        s.cursor = m_cursor; s.valid = m_valid; s.idx = m_idx; s.x = m_x; s.vis = m_vis;
        exp_q.push_back(s);
        @(negedge clk);
    endtask

    task automatic drive(bit l, bit r, bit s, bit f);
        btn_left = l; btn_right = r; btn_select = s; frame_start = f;
        tick();
        btn_left = 0; btn_right = 0; btn_select = 0; frame_start = 0;
    endtask

    // Monitor: compares every post-edge snapshot and every accepted selection
    initial begin
        snap_t s;
        bit    prev_valid;
        int    prev_idx;
        int    e;
        prev_valid = 0;
        prev_idx   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && prev_valid && sel_ready) begin
                if (sel_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL handshake: got index %0d expected no offer at %0t", prev_idx, $time);
                end else begin
                    e = sel_q.pop_front();
                    chk("handshake_index", prev_idx, e);
                end
            end
            if (exp_q.size() != 0) begin
                s = exp_q.pop_front();
                chk("cursor_idx", int'(cursor_idx), s.cursor);
                chk("sel_valid", int'(sel_valid), s.valid);
                chk("sel_index", int'(sel_index), s.idx);
                chk("x_pin", int'(x_pin), s.x);
                chk("y_pin", int'(y_pin), Y_ORIGIN);
                chk("hl_visible", int'(hl_visible), s.vis);
                chk("x_width", int'(x_width), CARD_W);
                chk("y_width", int'(y_width), CARD_H);
            end
            prev_valid = sel_valid;
            prev_idx   = int'(sel_index);
        end
    end

    // Stimulus
    initial begin
        rst_n = 0; turn_en = 0; hand_count = 0;
        btn_left = 0; btn_right = 0; btn_select = 0; frame_start = 0; sel_ready = 0;

        repeat (3) tick();
        chk("rst_cursor", int'(cursor_idx), 0);
        chk("rst_x_pin", int'(x_pin), X_ORIGIN);
        chk("rst_hl_visible", int'(hl_visible), 0);

        // Scenario 1: three rights then a frame
        rst_n = 1; turn_en = 1; hand_count = 5;
        tick();
        repeat (3) drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);
        chk("s1_cursor", int'(cursor_idx), 3);
        chk("s1_x_pin", int'(x_pin), 148);
        chk("s1_visible", int'(hl_visible), 1);

        // Scenario 2: wrap both ways, simultaneous buttons
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("s2_wrap_right", int'(cursor_idx), 0);
        drive(1, 0, 0, 0);
        chk("s2_wrap_left", int'(cursor_idx), 4);
        drive(1, 1, 0, 0);
        chk("s2_both", int'(cursor_idx), 4);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);

        // Scenario 3: select with a same-cycle move, ready held off
        drive(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            chk("s3_valid_held", int'(sel_valid), 1);
            chk("s3_index_held", int'(sel_index), 2);
            tick();
        end
        sel_ready = 1;
        tick();
        sel_ready = 0;
        chk("s3_valid_drop", int'(sel_valid), 0);
        drive(0, 1, 0, 0);
        chk("s3_browse_again", int'(cursor_idx), 3);
        drive(1, 0, 0, 0);

        // Scenario 4: blink while the offer is pending
        drive(0, 0, 1, 0);
        for (int k = 1; k <= 30; k++) begin
            drive(0, 0, 0, 1);
            if (k == 1)  chk("s4_blink_f1", int'(hl_visible), 1);
            if (k == 15) chk("s4_blink_f15", int'(hl_visible), 0);
            if (k == 30) chk("s4_blink_f30", int'(hl_visible), 1);
            tick();
        end
        sel_ready = 1;
        tick();
        sel_ready = 0;

        // Scenario 5: hand shrinks under the cursor, then empties
        hand_count = 8;
        tick();
        repeat (4) drive(0, 1, 0, 0);
        chk("s5_cursor6", int'(cursor_idx), 6);
        hand_count = 4;
        tick();
        chk("s5_clamp", int'(cursor_idx), 3);
        hand_count = 0;
        tick();
        drive(0, 0, 0, 1);
        chk("s5_idle_hidden", int'(hl_visible), 0);

        // Scenario 6: reset while an offer is pending
        hand_count = 5;
        tick();
        drive(0, 0, 1, 0);
        chk("s6_offer", int'(sel_valid), 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("s6_valid", int'(sel_valid), 0);
        chk("s6_x_pin", int'(x_pin), X_ORIGIN);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 49) == 0) turn_en = ~turn_en;
            if ($urandom_range(0, 49) == 0) hand_count = 5'($urandom_range(0, MAX_CARDS));
            btn_left    = ($urandom_range(0, 3) == 0);
            btn_right   = ($urandom_range(0, 3) == 0);
            btn_select  = ($urandom_range(0, 9) == 0);
            frame_start = ($urandom_range(0, 7) == 0);
            sel_ready   = ($urandom_range(0, 2) == 0);
            tick();
        end
        btn_left = 0; btn_right = 0; btn_select = 0; frame_start = 0; sel_ready = 0;
        tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
